// File: rtl/decode_branch_unit.sv
// IF/ID pipeline register plus B/BR branch resolution. Resolution outputs are combinational from IF/ID, so a redirect reaches Fetch in the same cycle.
// IF/ID freezes on hold or on a flag stall, loads a bubble after a redirect, and otherwise captures Fetch every cycle.
module decode_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flags_ready,
    input  logic [15:0] PC_curr,
    input  logic [15:0] PC_next,
    input  logic [15:0] PC_inst,
    input  logic [1:0]  prediction,
    input  logic [15:0] predicted_target,
    input  logic [2:0]  flags,
    input  logic [15:0] rs_data,
    output logic [15:0] IF_ID_PC_curr,
    output logic [15:0] IF_ID_PC_next,
    output logic [15:0] IF_ID_inst,
    output logic [1:0]  IF_ID_prediction,
    output logic        IF_ID_valid,
    output logic        is_branch,
    output logic        actual_taken,
    output logic        wen_BTB,
    output logic        wen_BHT,
    output logic        update_PC,
    output logic        stall_req,
    output logic [15:0] actual_target,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt
);

    logic [15:0] if_id_pred_target;
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        cond_true;
    logic        resolved;
    logic        target_miss;
    logic [15:0] branch_target;

    assign opcode = IF_ID_inst[15:12];
    assign ccc    = IF_ID_inst[11:9];
    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // B offsets are in halfwords relative to the fall-through PC; BR jumps to the register value.
    assign branch_target = (opcode == 4'hC)
                         ? IF_ID_PC_next + {{6{IF_ID_inst[8]}}, IF_ID_inst[8:0], 1'b0}
                         : rs_data;

    // Gating with rst keeps every resolution output low while reset is asserted.
    assign is_branch     = rst & IF_ID_valid & ((opcode == 4'hC) | (opcode == 4'hD));
    assign stall_req     = is_branch & ~flags_ready & (ccc != 3'b111);
    assign resolved      = is_branch & ~hold & (flags_ready | (ccc == 3'b111));
    assign actual_taken  = is_branch & cond_true;
    assign actual_target = actual_taken ? branch_target : IF_ID_PC_next;
    assign target_miss   = if_id_pred_target != branch_target;
    assign wen_BHT       = resolved;
    assign wen_BTB       = resolved & actual_taken & target_miss;
    assign update_PC     = resolved & ((IF_ID_prediction[1] != actual_taken) | (actual_taken & target_miss));

    always_ff @(posedge clk) begin
        if (!rst) begin
            IF_ID_PC_curr     <= '0;
            IF_ID_PC_next     <= '0;
            IF_ID_inst        <= '0;
            IF_ID_prediction  <= '0;
            if_id_pred_target <= '0;
            IF_ID_valid       <= 1'b0;
        end else if (hold || stall_req) begin
            IF_ID_valid <= IF_ID_valid;
        end else if (update_PC) begin
            // Squash the wrong-path instruction Fetch delivered this cycle.
            IF_ID_PC_curr     <= '0;
            IF_ID_PC_next     <= '0;
            IF_ID_inst        <= 16'h0000;
            IF_ID_prediction  <= '0;
            if_id_pred_target <= '0;
            IF_ID_valid       <= 1'b0;
        end else begin
            IF_ID_PC_curr     <= PC_curr;
            IF_ID_PC_next     <= PC_next;
            IF_ID_inst        <= PC_inst;
            IF_ID_prediction  <= prediction;
            if_id_pred_target <= predicted_target;
            IF_ID_valid       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolved && branch_cnt != 16'hFFFF) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (update_PC && mispredict_cnt != 16'hFFFF) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_branch_unit.sv
// Randomized and directed bench for decode_branch_unit against a field-level behavioural model.
module tb_decode_branch_unit;

    typedef struct {
        logic        r;
        logic        h;
        logic        fr;
        logic [15:0] pc;
        logic [15:0] pn;
        logic [15:0] inst;
        logic [1:0]  pred;
        logic [15:0] pt;
        logic [2:0]  fl;
        logic [15:0] rs;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hold, flags_ready;
    logic [15:0] PC_curr, PC_next, PC_inst, predicted_target, rs_data;
    logic [1:0]  prediction;
    logic [2:0]  flags;
    logic [15:0] IF_ID_PC_curr, IF_ID_PC_next, IF_ID_inst, actual_target, branch_cnt, mispredict_cnt;
    logic [1:0]  IF_ID_prediction;
    logic        IF_ID_valid, is_branch, actual_taken, wen_BTB, wen_BHT, update_PC, stall_req;

    decode_branch_unit dut (
        .clk(clk), .rst(rst), .hold(hold), .flags_ready(flags_ready),
        .PC_curr(PC_curr), .PC_next(PC_next), .PC_inst(PC_inst),
        .prediction(prediction), .predicted_target(predicted_target),
        .flags(flags), .rs_data(rs_data),
        .IF_ID_PC_curr(IF_ID_PC_curr), .IF_ID_PC_next(IF_ID_PC_next), .IF_ID_inst(IF_ID_inst),
        .IF_ID_prediction(IF_ID_prediction), .IF_ID_valid(IF_ID_valid),
        .is_branch(is_branch), .actual_taken(actual_taken), .wen_BTB(wen_BTB), .wen_BHT(wen_BHT),
        .update_PC(update_PC), .stall_req(stall_req), .actual_target(actual_target),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: the IF/ID slot and the two counters.
    logic        m_valid = 1'b0;
    logic [15:0] m_pc = '0, m_pn = '0, m_inst = '0, m_pt = '0;
    logic [1:0]  m_pred = '0;
    logic [15:0] m_bcnt = '0, m_mcnt = '0;

    logic [15:0] obs_target, obs_bcnt, obs_mcnt, obs_inst;
    logic        obs_taken, obs_upd, obs_wbtb, obs_wbht, obs_stall, obs_valid;

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] fl);
        logic z, v, n;
        z = fl[2]; v = fl[1]; n = fl[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] b_target(input logic [15:0] pn, input logic [8:0] off9);
        int off;
        off = off9[8] ? int'(off9) - 512 : int'(off9);
        return 16'((int'(pn) + 2 * off) & 32'hFFFF);
    endfunction

    task automatic cycle(input stim_t st);
        logic        br, tk, stl, res, wbtb, upd, is_b;
        logic [15:0] tgt, atgt;
        @(negedge clk);
        rst = st.r; hold = st.h; flags_ready = st.fr;
        PC_curr = st.pc; PC_next = st.pn; PC_inst = st.inst;
        prediction = st.pred; predicted_target = st.pt; flags = st.fl; rs_data = st.rs;
        #1;
        is_b = (m_inst[15:12] == 4'hC);
        br   = st.r && m_valid && (is_b || m_inst[15:12] == 4'hD);
        tgt  = is_b ? b_target(m_pn, m_inst[8:0]) : st.rs;
        tk   = br && cond_holds(m_inst[11:9], st.fl);
        atgt = tk ? tgt : m_pn;
        stl  = br && !st.fr && m_inst[11:9] != 3'b111;
        res  = br && !st.h && (st.fr || m_inst[11:9] == 3'b111);
        wbtb = res && tk && (m_pt != tgt);
        upd  = res && ((m_pred[1] != tk) || (tk && m_pt != tgt));
        check("valid",   16'(IF_ID_valid), 16'(m_valid));
        check("pc_curr", IF_ID_PC_curr, m_pc);
        check("pc_next", IF_ID_PC_next, m_pn);
        check("inst",    IF_ID_inst, m_inst);
        check("pred",    16'(IF_ID_prediction), 16'(m_pred));
        check("is_br",   16'(is_branch), 16'(br));
        check("taken",   16'(actual_taken), 16'(tk));
        check("target",  actual_target, atgt);
        check("stall",   16'(stall_req), 16'(stl));
        check("wen_bht", 16'(wen_BHT), 16'(res));
        check("wen_btb", 16'(wen_BTB), 16'(wbtb));
        check("upd_pc",  16'(update_PC), 16'(upd));
        check("bcnt",    branch_cnt, m_bcnt);
        check("mcnt",    mispredict_cnt, m_mcnt);
        obs_target = actual_target; obs_taken = actual_taken; obs_upd = update_PC;
        obs_wbtb = wen_BTB; obs_wbht = wen_BHT; obs_stall = stall_req;
        obs_bcnt = branch_cnt; obs_mcnt = mispredict_cnt; obs_inst = IF_ID_inst; obs_valid = IF_ID_valid;
        @(posedge clk);
        if (!st.r) begin
            m_valid = 0; m_pc = '0; m_pn = '0; m_inst = '0; m_pred = '0; m_pt = '0;
            m_bcnt = '0; m_mcnt = '0;
        end else begin
            if (res && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 1;
            if (upd && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 1;
            if (st.h || stl) begin
                m_valid = m_valid;
            end else if (upd) begin
                m_valid = 0; m_pc = '0; m_pn = '0; m_inst = '0; m_pred = '0; m_pt = '0;
            end else begin
                m_valid = 1; m_pc = st.pc; m_pn = st.pn; m_inst = st.inst; m_pred = st.pred; m_pt = st.pt;
            end
        end
    endtask

    stim_t s;
    logic [15:0] b0;

    initial begin
        s = '{r: 1'b0, h: 1'b0, fr: 1'b1, pc: 16'h0, pn: 16'h0, inst: 16'h0,
              pred: 2'b00, pt: 16'h0, fl: 3'b000, rs: 16'h0};
        rst = 0; hold = 0; flags_ready = 1; PC_curr = 0; PC_next = 0; PC_inst = 0;
        prediction = 0; predicted_target = 0; flags = 0; rs_data = 0;

        // Reset with a branch presented: nothing may resolve.
        s.inst = 16'hCE04; s.h = 1;
        cycle(s); cycle(s);
        s.r = 1; s.h = 0; s.inst = 16'h0000;
        cycle(s);
        check("post_rst_valid", 16'(obs_valid), 16'd0);

        // Not-taken mispredict.
        s.inst = 16'hC204; s.pn = 16'h0010; s.pc = 16'h000F; s.pred = 2'b10; cycle(s);
        s.inst = 16'h0000; s.fl = 3'b000; s.pred = 2'b00; cycle(s);
        check("nt_taken", 16'(obs_taken), 16'd0);
        check("nt_target", obs_target, 16'h0010);
        check("nt_upd", 16'(obs_upd), 16'd1);
        check("nt_wbtb", 16'(obs_wbtb), 16'd0);
        cycle(s);
        check("nt_bubble", 16'(obs_valid), 16'd0);

        // Taken with a BTB miss.
        s.inst = 16'hCFFE; s.pn = 16'h0020; s.pred = 2'b11; s.pt = 16'h0000; cycle(s);
        s.inst = 16'h0000; s.pred = 2'b00; cycle(s);
        check("btb_target", obs_target, 16'h001C);
        check("btb_wbtb", 16'(obs_wbtb), 16'd1);
        check("btb_upd", 16'(obs_upd), 16'd1);

        // Correctly predicted BR.
        s.inst = 16'hDE10; s.pred = 2'b11; s.pt = 16'h1234; cycle(s);
        s.inst = 16'h0000; s.rs = 16'h1234; s.pt = 16'h0; s.pred = 2'b00;
        b0 = m_mcnt; cycle(s);
        check("br_upd", 16'(obs_upd), 16'd0);
        check("br_wbht", 16'(obs_wbht), 16'd1);
        cycle(s);
        check("br_mcnt", obs_mcnt, b0);

        // Flag stall for three cycles.
        s.inst = 16'hC004; s.pn = 16'h0040; cycle(s);
        s.inst = 16'h0000; s.fr = 0;
        repeat (3) begin
            cycle(s);
            check("stall_on", 16'(obs_stall), 16'd1);
            check("stall_frozen", obs_inst, 16'hC004);
        end
        b0 = obs_bcnt; s.fr = 1; cycle(s);
        check("stall_resolve", 16'(obs_wbht), 16'd1);
        cycle(s);
        check("stall_once", obs_bcnt, 16'(b0 + 16'd1));

        // Hold over a would-be redirect.
        s.inst = 16'hCE04; s.pred = 2'b00; cycle(s);
        s.inst = 16'h0000; s.h = 1;
        repeat (2) begin
            cycle(s);
            check("hold_upd", 16'(obs_upd), 16'd0);
            check("hold_inst", obs_inst, 16'hCE04);
        end
        s.h = 0; cycle(s);
        check("hold_release_upd", 16'(obs_upd), 16'd1);
        cycle(s);
        check("hold_single_pulse", 16'(obs_upd), 16'd0);

        // Reset in the middle of a stall discards the branch.
        s.inst = 16'hC004; cycle(s);
        s.inst = 16'h0000; s.fr = 0; cycle(s);
        s.r = 0; cycle(s);
        s.r = 1; s.fr = 1; cycle(s);
        check("rst_stall_bcnt", obs_bcnt, 16'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) < 6) ? (($urandom_range(0, 1) != 0) ? 4'hC : 4'hD) : 4'($urandom);
            s.r    = ($urandom_range(0, 59) != 0);
            s.h    = ($urandom_range(0, 4) == 0);
            s.fr   = ($urandom_range(0, 3) != 0);
            s.pc   = 16'($urandom);
            s.pn   = s.pc + 16'd1;
            s.inst = {op, 12'($urandom)};
            s.pred = 2'($urandom);
            s.fl   = 3'($urandom);
            s.pt   = ($urandom_range(0, 1) != 0) ? b_target(s.pn, s.inst[8:0]) : 16'($urandom);
            s.rs   = ($urandom_range(0, 1) != 0) ? m_pt : 16'($urandom);
            cycle(s);
        end

        // Saturation of the mispredict counter.
        s = '{r: 1'b1, h: 1'b0, fr: 1'b1, pc: 16'h0, pn: 16'h0100, inst: 16'h0000,
              pred: 2'b00, pt: 16'h0, fl: 3'b000, rs: 16'h0};
        cycle(s); cycle(s);
        #1;
        force dut.mispredict_cnt = 16'hFFFE;
        #1;
        release dut.mispredict_cnt;
        m_mcnt = 16'hFFFE;
        repeat (3) begin
            s.inst = 16'hCE04; cycle(s);
            s.inst = 16'h0000; cycle(s);
        end
        cycle(s);
        check("sat_mcnt", obs_mcnt, 16'hFFFF);
        s.r = 0; cycle(s);
        s.r = 1; cycle(s);
        check("rst_mcnt", obs_mcnt, 16'h0000);
        check("rst_bcnt", obs_bcnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
